// File: rtl/seq_mul_eight_eight.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_eight_eight
// Brief    : 8x8 unsigned multiplier built from two passes of an 8x4 array
//            multiplier, with valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
module seq_mul_eight_eight #(
    parameter int unsigned SKIP_ZERO_HI = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [7:0]  done_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_q;
    logic [7:0]  done_count_q;

    logic [7:0]       mul_a;
    logic [3:0]       mul_b;
    logic [3:0][11:0] mul_pp;
    logic [11:0]      mul_r;
    logic             skip_hi;

    // The one shared array multiplier sees the nibble selected by the state.
    always_comb begin
        mul_a = 8'd0;
        mul_b = 4'd0;
        case (state_q)
            S_LO: begin
                mul_a = a_q;
                mul_b = b_q[3:0];
            end
            S_HI: begin
                mul_a = a_q;
                mul_b = b_q[7:4];
            end
            default: begin
                mul_a = 8'd0;
                mul_b = 4'd0;
            end
        endcase
    end

    generate
        for (genvar j = 0; j < 4; j++) begin : g_pp_row
            assign mul_pp[j] = {4'b0000, mul_a & {8{mul_b[j]}}} << j;
        end
    endgenerate

    assign mul_r   = mul_pp[0] + mul_pp[1] + mul_pp[2] + mul_pp[3];
    assign skip_hi = (SKIP_ZERO_HI != 0) && (b_q[7:4] == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            acc_q        <= 16'd0;
            done_count_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    acc_q   <= {4'b0000, mul_r};
                    state_q <= skip_hi ? S_DONE : S_HI;
                end
                S_HI: begin
                    acc_q   <= acc_q + {mul_r, 4'b0000};
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        done_count_q <= done_count_q + 8'd1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // in_ready is gated by rst so nothing is offered while reset is held.
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign product    = acc_q;
    assign done_count = done_count_q;

endmodule
`default_nettype wire
